// File: rtl/wishbone_master.sv
// Wishbone classic single-transfer initiator: one cyc/stb cycle per valid/ready request.
// Optional bus watchdog is enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_master #(
    parameter int unsigned MAX_RETRIES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic [31:0] rsp_rdata_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUS     = 2'd1;
    localparam logic [1:0] S_BACKOFF = 2'd2;

    localparam int unsigned RETRY_W = 8;
    localparam int unsigned WD_W    = 16;

    if (MAX_RETRIES < 1 || MAX_RETRIES > 255 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("wishbone_master: parameter out of range");
    end

    logic [1:0]         state, state_n;
    logic [RETRY_W-1:0] retry_cnt, retry_n;
    logic               cyc_n, stb_n, we_n;
    logic [31:0]        adr_n, dat_n;
    logic [3:0]         sel_n;
    logic               rsp_valid_n, rsp_err_n;
    logic [31:0]        rsp_rdata_n;
    logic               last_try;
    logic               timeout;

    assign req_ready_o = (state == S_IDLE) && !rst_i;

    // This rty would be the MAX_RETRIES-th one, so it ends the request with an error.
    assign last_try = (32'(retry_cnt) + 32'd1) >= MAX_RETRIES;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt, wd_n;

    assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Zero outside BUS so every entry into BUS starts a fresh count.
    always_comb begin
        wd_n = '0;
        if (state == S_BUS && !(err_i || ack_i || rty_i)) begin
            wd_n = wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        retry_n     = retry_cnt;
        cyc_n       = cyc_o;
        stb_n       = stb_o;
        we_n        = we_o;
        adr_n       = adr_o;
        sel_n       = sel_o;
        dat_n       = dat_o;
        rsp_valid_n = 1'b0;
        rsp_err_n   = rsp_err_o;
        rsp_rdata_n = rsp_rdata_o;

        case (state)
            S_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    adr_n   = req_addr_i & ~32'h3;
                    we_n    = req_we_i;
                    sel_n   = req_sel_i;
                    dat_n   = req_wdata_i;
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                    retry_n = '0;
                    state_n = S_BUS;
                end
            end
            S_BUS: begin
                // Priority err > ack > rty > watchdog.
                if (err_i || (!ack_i && ((rty_i && last_try) || (!rty_i && timeout)))) begin
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                    state_n     = S_IDLE;
                end else if (ack_i) begin
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_rdata_n = we_o ? 32'h0 : dat_i;
                    state_n     = S_IDLE;
                end else if (rty_i) begin
                    retry_n = retry_cnt + RETRY_W'(1);
                    cyc_n   = 1'b0;
                    stb_n   = 1'b0;
                    state_n = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                cyc_n   = 1'b1;
                stb_n   = 1'b1;
                state_n = S_BUS;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            retry_cnt   <= '0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            sel_o       <= 4'b0000;
            dat_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            state       <= state_n;
            retry_cnt   <= retry_n;
            cyc_o       <= cyc_n;
            stb_o       <= stb_n;
            we_o        <= we_n;
            adr_o       <= adr_n;
            sel_o       <= sel_n;
            dat_o       <= dat_n;
            rsp_valid_o <= rsp_valid_n;
            rsp_err_o   <= rsp_err_n;
            rsp_rdata_o <= rsp_rdata_n;
        end
    end

endmodule

// File: tb/tb_wishbone_master.sv
// Bench for wishbone_master: memory slave model, reference memory and a response scoreboard.
// The unmapped-access watchdog case runs only when WB_MASTER_TIMEOUT_EN is defined.
module tb_wishbone_master;

    localparam int unsigned MR    = 4;
    localparam int unsigned TO    = 8;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned WORDS = 16384;
    localparam int          NRAND = 60;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic [3:0]  req_sel_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i, rty_i;

    wishbone_master #(.MAX_RETRIES(MR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          cyc_hi;
        logic [31:0] adr;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    logic [31:0] ref_mem[int];
    logic [31:0] smem[int];

    // Slave behaviour for the transfer in flight, set by the stimulus while the bus is idle.
    int   plan_rty = 0;
    int   plan_err = 0;
    logic plan_stall = 1'b0;
    int   rty_seen;

    always @(posedge clk) cycle++;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    function automatic logic mapped(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 4 * WORDS);
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Registered memory slave: one termination per strobe; dat_i is noise except on a read ack.
    always @(posedge clk) begin
        int idx;
        ack_i <= 1'b0;
        err_i <= 1'b0;
        rty_i <= 1'b0;
        dat_i <= $urandom;
        if (rst_i || rsp_valid_o) begin
            rty_seen <= 0;
        end else if (cyc_o && stb_o && !ack_i && !err_i && !rty_i && !plan_stall && mapped(adr_o)) begin
            if (plan_err != 0) begin
                err_i <= 1'b1;
                ack_i <= (plan_err == 2);
            end else if (rty_seen < plan_rty) begin
                rty_i    <= 1'b1;
                rty_seen <= rty_seen + 1;
            end else begin
                ack_i <= 1'b1;
                idx = int'((adr_o - BASE) >> 2);
                if (we_o) smem[idx] = lanes(smem.exists(idx) ? smem[idx] : 32'h0, dat_o, sel_o);
                else      dat_i <= smem.exists(idx) ? smem[idx] : 32'h0;
            end
        end
    end

    // Monitor: pops one expectation per response pulse.
    int          cyc_run = 0;
    logic [31:0] seen_adr = '0;
    always @(negedge clk) begin
        exp_t e;
        int   acc;
        if (rst_i) begin
            acc_q.delete();
            cyc_run = 0;
        end else begin
            if (cyc_o) begin
                cyc_run++;
                seen_adr = adr_o;
            end
            if (rsp_valid_o) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got a response pulse, expected none (cycle %0d)", cycle);
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    check("rsp_err", 32'(rsp_err_o), 32'(e.err));
                    check("rsp_rdata", rsp_rdata_o, e.rdata);
                    check("accept_to_rsp_clocks", 32'(cycle - acc), 32'(e.lat));
                    check("cyc_high_clocks", 32'(cyc_run), 32'(e.cyc_hi));
                    check("adr_o", seen_adr, e.adr);
                end
                cyc_run = 0;
            end
            if (req_valid_i && req_ready_o) acc_q.push_back(cycle);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                checks++;
                failures++;
                $display("FAIL drain: %0d responses still outstanding, expected 0", exp_q.size());
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one request; the expected response comes from the reference memory and the plan.
    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] sel, input logic [31:0] wd,
                         input int rty, input int errm, input logic chained, input logic stall);
        exp_t e;
        int   attempts, idx, n;
        if (!chained) begin
            drain();
            plan_rty   = rty;
            plan_err   = errm;
            plan_stall = stall;
        end
        idx   = int'((a - BASE) >> 2);
        e.adr = a & ~32'h3;
        if (!mapped(a)) begin
            e.err = 1'b1;
            e.rdata = 32'h0;
            e.cyc_hi = TO;
            e.lat = TO + 1;
        end else begin
            attempts = (errm != 0) ? 1 : ((rty < int'(MR) - 1) ? rty + 1 : int'(MR));
            e.err    = (errm != 0) || (rty >= int'(MR));
            e.cyc_hi = 2 * attempts;
            e.lat    = 3 * attempts;
            e.rdata  = 32'h0;
            if (!e.err && we) ref_mem[idx] = lanes(ref_mem.exists(idx) ? ref_mem[idx] : 32'h0, wd, sel);
            if (!e.err && !we) e.rdata = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        end
        if (!stall) exp_q.push_back(e);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_we_i    = we;
        req_sel_i   = sel;
        req_wdata_i = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready_o) begin
            n++;
            if (n > 200) begin
                $display("FAIL accept: req_ready_o stayed 0, expected 1 within 200 clocks");
                $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
                $fatal(1, "request never accepted");
            end
            @(negedge clk);
        end
        if (chained) check("b2b_accept_in_rsp_cycle", 32'(rsp_valid_o), 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r_adr[NRAND];
    logic [31:0] r_wd[NRAND];
    logic [3:0]  r_sel[NRAND];
    logic        r_we[NRAND];
    int          r_rty[NRAND];
    int          r_err[NRAND];
    logic        r_ch[NRAND];

    initial begin
        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready_o), 32'd0);
        check("reset_cyc_stb", {30'd0, cyc_o, stb_o}, 32'd0);
        check("reset_we_rspvalid_err", {29'd0, we_o, rsp_valid_o, rsp_err_o}, 32'd0);
        check("reset_adr", adr_o, 32'd0);
        check("reset_dat_sel", dat_o | 32'(sel_o), 32'd0);
        check("reset_rdata", rsp_rdata_o, 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;

        // Write then read back.
        issue(32'h1004, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h1004, 1'b0, 4'hF, 32'h0,         0, 0, 1'b0, 1'b0); req_valid_i = 1'b0;

        // Byte lanes.
        issue(32'h1008, 1'b1, 4'hF, 32'h1122_3344, 0, 0, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h1008, 1'b1, 4'h5, 32'hAABB_CCDD, 0, 0, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h1008, 1'b0, 4'hF, 32'h0,         0, 0, 1'b0, 1'b0); req_valid_i = 1'b0;

        // Back-to-back reads with valid held high.
        issue(32'h1000, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 1'b0);
        issue(32'h1004, 1'b0, 4'hF, 32'h0, 0, 0, 1'b1, 1'b0);
        issue(32'h1008, 1'b0, 4'hF, 32'h0, 0, 0, 1'b1, 1'b0); req_valid_i = 1'b0;

        // Retries, up to and past the limit.
        issue(32'h100C, 1'b1, 4'hF, 32'h0000_00A5, 0, 0, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h100C, 1'b0, 4'hF, 32'h0, 2, 0, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h100F, 1'b0, 4'hF, 32'h0, 3, 0, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h100C, 1'b0, 4'hF, 32'h0, 4, 0, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h1010, 1'b1, 4'hF, 32'h5A5A_5A5A, 5, 0, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h1010, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 1'b0); req_valid_i = 1'b0;

        // Error terminations, alone and together with ack.
        issue(32'h1004, 1'b0, 4'hF, 32'h0, 0, 1, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h1004, 1'b1, 4'hF, 32'h0BAD_0BAD, 0, 2, 1'b0, 1'b0); req_valid_i = 1'b0;
        issue(32'h1004, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 1'b0); req_valid_i = 1'b0;

`ifdef WB_MASTER_TIMEOUT_EN
        issue(32'h0000_0000, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 1'b0); req_valid_i = 1'b0;
`endif

        // Reset while the slave is stalled.
        issue(32'h1014, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 1'b1); req_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cyc_before_reset", 32'(cyc_o), 32'd1);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check("ready_during_reset", 32'(req_ready_o), 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("cyc_stb_after_reset", {30'd0, cyc_o, stb_o}, 32'd0);
        check("ready_after_midreset", 32'(req_ready_o), 32'd1);
        repeat (6) @(negedge clk);
        plan_stall = 1'b0;

        // Randomized traffic; chaining only between clean transfers so the slave plan stays fixed.
        for (int i = 0; i < NRAND; i++) begin
            r_adr[i] = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            r_we[i]  = 1'($urandom_range(0, 1));
            r_sel[i] = 4'($urandom_range(0, 15));
            r_wd[i]  = $urandom;
            r_rty[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            r_err[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            r_ch[i]  = (i > 0) && (r_rty[i] == 0) && (r_err[i] == 0) && (r_rty[i-1] == 0) &&
                       (r_err[i-1] == 0) && ($urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < NRAND; i++) begin
            issue(r_adr[i], r_we[i], r_sel[i], r_wd[i], r_rty[i], r_err[i], r_ch[i], 1'b0);
            if (!(i + 1 < NRAND && r_ch[i+1])) req_valid_i = 1'b0;
        end
        drain();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench still running, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "global timeout");
    end

endmodule
